// File: rtl/digit_scan_mux_if.sv
// digit_scan_mux_if: load/value/blanking inputs and scan outputs of the digit scanner.
interface digit_scan_mux_if #(parameter int NUM_DIGITS = 4);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    lz_blank;
  logic [3:0]              nibble;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [IW-1:0]           digit_idx;
  logic                    frame_done;
  modport master(output load, value, lz_blank, input nibble, digit_en, digit_idx, frame_done);
  modport slave(input load, value, lz_blank, output nibble, digit_en, digit_idx, frame_done);
endinterface

// File: rtl/digit_scan_mux.sv
// digit_scan_mux: multiplexed 7-segment digit scanner with frame-aligned updates and zero blanking.
module digit_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DIV_WIDTH   = 16
) (
  input logic clk,
  input logic rst,
  digit_scan_mux_if.slave bus
);
  localparam int W  = 4*NUM_DIGITS;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [DIV_WIDTH-1:0] cnt;
  logic [IW-1:0] idx;
  logic [W-1:0] shadow, active;
  logic pending, slot_end, wrap;
  logic [NUM_DIGITS-1:0] keep;
  assign slot_end = cnt == DIV_WIDTH'(REFRESH_DIV-1);
  assign wrap     = slot_end && idx == IW'(NUM_DIGITS-1);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= idx == IW'(NUM_DIGITS-1) ? '0 : idx + 1'b1;
      if (bus.load) shadow <= bus.value;
      // a load landing on the wrap cycle bypasses the shadow so it is not lost for a frame
      if (wrap) begin
        active  <= bus.load ? bus.value : pending ? shadow : active;
        pending <= 1'b0;
      end else if (bus.load) pending <= 1'b1;
    end
  end
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_keep
    assign keep[g] = (g == 0) || !bus.lz_blank || (active >> (4*g)) != '0;
  end
  always_comb begin
    bus.nibble     = active[{idx, 2'b00} +: 4];
    bus.digit_en   = (cnt != '0 && keep[idx]) ? NUM_DIGITS'(1) << idx : '0;
    bus.digit_idx  = idx;
    bus.frame_done = wrap;
  end
endmodule

// File: tb/tb_digit_scan_mux.sv
// tb_digit_scan_mux: directed and random scan checks against a frame-level display model.
module tb_digit_scan_mux;
  logic clk = 0;
  logic rst = 1;
  int checks = 0, errors = 0;
  int cy = 0;
  bit prev_r = 1;
  logic lz = 0;
  digit_scan_mux_if #(.NUM_DIGITS(4)) bus();
  digit_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DIV_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  // model: time within the frame, the displayed value, and the newest value loaded since reset
  int t = 0;
  logic [15:0] act = 0, latest = 0;
  bit mvalid = 0;
  always @(posedge clk) begin
    if (rst) begin
      t = 0; act = 0; latest = 0; mvalid = 1;
    end else if (mvalid) begin
      if (t == 15) act = bus.load ? bus.value : latest;
      if (bus.load) latest = bus.value;
      t = (t + 1) % 16;
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cy, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      int slot, pos;
      logic [15:0] rest;
      logic lit;
      slot = t / 4;
      pos  = t % 4;
      rest = act >> (4*slot);
      lit  = slot == 0 || !bus.lz_blank || rest != 0;
      chk("model_nibble", bus.nibble, rest & 16'hF);
      chk("model_digit_en", bus.digit_en, (pos != 0 && lit) ? (32'd1 << slot) : 32'd0);
      chk("model_digit_idx", bus.digit_idx, slot);
      chk("model_frame_done", bus.frame_done, t == 15);
    end
  end

  task automatic step(input logic r, input logic l, input logic [15:0] v);
    @(posedge clk);
    #2;
    cy = prev_r ? 0 : cy + 1;
    prev_r = r;
    rst = r;
    bus.load = l;
    bus.value = v;
    bus.lz_blank = lz;
  endtask

  task automatic run_to(input int c);
    while (prev_r || cy < c) step(0, 0, 16'h0);
  endtask

  task automatic at(input int c);
    run_to(c);
    #4;
  endtask

  task automatic ld(input int c, input logic [15:0] v);
    run_to(c - 1);
    step(0, 1, v);
  endtask

  initial begin
    bus.load = 0; bus.value = 0; bus.lz_blank = 0;
    step(1, 0, 0); step(1, 0, 0);
    at(0);  chk("rst_en", bus.digit_en, 0); chk("rst_nibble", bus.nibble, 0); chk("rst_fd", bus.frame_done, 0);
    at(1);  chk("c1_en", bus.digit_en, 4'b0001); chk("c1_nibble", bus.nibble, 0);
    at(4);  chk("c4_en", bus.digit_en, 0); chk("c4_idx", bus.digit_idx, 1);
    ld(6, 16'h1234);
    at(8);  chk("c8_idx", bus.digit_idx, 2);
    at(12); chk("c12_idx", bus.digit_idx, 3);
    at(13); chk("old_frame_nibble", bus.nibble, 0); chk("c13_en", bus.digit_en, 4'b1000);
    at(14); chk("fd_low", bus.frame_done, 0);
    at(15); chk("fd_15", bus.frame_done, 1);
    at(16); chk("c16_idx", bus.digit_idx, 0);
    at(17); chk("d0_en", bus.digit_en, 4'b0001); chk("d0_nib", bus.nibble, 4);
    at(21); chk("d1_en", bus.digit_en, 4'b0010); chk("d1_nib", bus.nibble, 3);
    at(25); chk("d2_en", bus.digit_en, 4'b0100); chk("d2_nib", bus.nibble, 2);
    at(29); chk("d3_en", bus.digit_en, 4'b1000); chk("d3_nib", bus.nibble, 1);
    ld(30, 16'h0070);
    at(31); chk("fd_31", bus.frame_done, 1);
    lz = 1;
    at(33); chk("lz_d0_en", bus.digit_en, 4'b0001); chk("lz_d0_nib", bus.nibble, 0);
    at(37); chk("lz_d1_en", bus.digit_en, 4'b0010); chk("lz_d1_nib", bus.nibble, 7);
    at(41); chk("lz_d2_en", bus.digit_en, 0);
    at(45); chk("lz_d3_en", bus.digit_en, 0);
    ld(46, 16'h0000);
    at(47); chk("fd_47", bus.frame_done, 1);
    at(49); chk("zero_d0_en", bus.digit_en, 4'b0001); chk("zero_d0_nib", bus.nibble, 0);
    at(53); chk("zero_d1_en", bus.digit_en, 0);
    lz = 0;
    at(57); chk("unblank_d2_en", bus.digit_en, 4'b0100);
    at(61); chk("unblank_d3_en", bus.digit_en, 4'b1000);
    ld(67, 16'hAAAA);
    ld(73, 16'hBBBB);
    at(81); chk("last_wins_d0_en", bus.digit_en, 4'b0001); chk("last_wins_d0", bus.nibble, 4'hB);
    at(93); chk("last_wins_d3", bus.nibble, 4'hB);
    ld(95, 16'hC0DE);
    at(97);  chk("bypass_en", bus.digit_en, 4'b0001); chk("bypass_nib", bus.nibble, 4'hE);
    at(113); chk("bypass_hold", bus.nibble, 4'hE);
    for (int i = 0; i < 600; i++) begin
      logic [15:0] v;
      v = 16'($urandom) & (16'hFFFF >> (4*$urandom_range(0, 4)));
      if ($urandom_range(0, 19) == 0) lz = ~lz;
      step($urandom_range(0, 149) == 0, $urandom_range(0, 5) == 0, v);
    end
    lz = 0;
    step(1, 0, 0);
    ld(5, 16'h1234);
    at(17); chk("pre_rst_nib", bus.nibble, 4);
    ld(18, 16'h5678);
    run_to(19);
    step(1, 0, 0);
    at(0);  chk("midrst_en", bus.digit_en, 0); chk("midrst_idx", bus.digit_idx, 0);
    at(1);  chk("midrst_nib0", bus.nibble, 0);
    at(5);  chk("midrst_nib1", bus.nibble, 0);
    at(9);  chk("midrst_nib2", bus.nibble, 0);
    at(13); chk("midrst_nib3", bus.nibble, 0);
    at(17); chk("midrst_next0", bus.nibble, 0);
    at(21); chk("midrst_next1", bus.nibble, 0);
    step(0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
